// File: rtl/pfb_deadlock_monitor_param_pkg.sv
// Shared types and helpers for the PFB/correlator dataflow deadlock monitor.
package pfb_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SUSPECT = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    // Ceiling log2, for sizing index and counter fields from parameters.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value >= max_value) ? max_value : value + 64'd1;
    endfunction

endpackage

// File: rtl/pfb_deadlock_monitor_param_if.sv
// Status bundle between the dataflow block flags and the deadlock monitor.
interface pfb_deadlock_monitor_param_if #(
    parameter int N_AXIS = 2,
    parameter int N_INST = 1,
    parameter int CNT_W  = 16,
    localparam int CHAN_W = pfb_deadlock_pkg::clog2(N_AXIS + 1)
);
    logic [N_AXIS-1:0] axis_block_sigs;
    logic [N_INST-1:0] inst_idle_sigs;
    logic [N_INST-1:0] inst_block_sigs;
    logic              clear;
    logic              block;
    logic [CHAN_W-1:0] block_chan_idx;
    logic [CNT_W-1:0]  block_cycles;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        input  block, block_chan_idx, block_cycles
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs, clear,
        output block, block_chan_idx, block_cycles
    );
endinterface

// File: rtl/pfb_deadlock_monitor_param_prio_enc.sv
// Lowest-index priority encoder; idx = N when no request is set.
module pfb_deadlock_prio_enc
    import pfb_deadlock_pkg::*;
#(
    parameter int  N     = 2,
    localparam int IDX_W = clog2(N + 1)
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx,
    output logic             vld
);

    // Scan downward so the lowest set bit is the last one written.
    always_comb begin
        idx = IDX_W'(N);
        vld = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pfb_deadlock_monitor_param.sv
// Deadlock monitor: flags persistent stream/instance blocking, reports the
// first blocking channel and a saturating blocked-duration count.
module pfb_deadlock_monitor_param
    import pfb_deadlock_pkg::*;
#(
    parameter int                N_AXIS    = 2,
    parameter int                N_INST    = 1,
    parameter logic [N_AXIS-1:0] CHAN_MASK = '1,
    parameter bit                INST_EN   = 1'b0,
    parameter int                THRESH    = 1,
    parameter bit                STICKY    = 1'b0,
    parameter int                CNT_W     = 16,
    localparam int               CHAN_W    = clog2(N_AXIS + 1)
) (
    input logic clock,
    input logic reset,
    pfb_deadlock_monitor_param_if.slave mon
);

    localparam int               PCNT_W    = clog2(THRESH + 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(THRESH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t            state;
    logic [PCNT_W-1:0] persist_cnt;
    logic              block_q;
    logic [CHAN_W-1:0] chan_q;
    logic [CNT_W-1:0]  cycles_q;

    logic [N_AXIS-1:0] axis_qual;
    logic [CHAN_W-1:0] first_chan;
    logic              axis_cand;
    logic              inst_cand;
    logic              cand;
    logic              enter_blk;
    logic              stay_blk;
    logic              unused_idle;

    assign axis_qual = mon.axis_block_sigs & CHAN_MASK;

    pfb_deadlock_prio_enc #(
        .N (N_AXIS)
    ) u_prio_enc (
        .req (axis_qual),
        .idx (first_chan),
        .vld (axis_cand)
    );

    assign inst_cand   = INST_EN && (|mon.inst_block_sigs);
    assign cand        = axis_cand | inst_cand;
    // Idle flags are carried for future modes; keep them on the port list.
    assign unused_idle = ^mon.inst_idle_sigs;

    always_comb begin
        enter_blk = 1'b0;
        case (state)
            IDLE:    enter_blk = cand && (THRESH == 1);
            SUSPECT: enter_blk = cand && (persist_cnt == PCNT_LAST);
            default: enter_blk = 1'b0;
        endcase
    end

    assign stay_blk = (state == BLOCKED) && (cand || STICKY);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            persist_cnt <= '0;
            block_q     <= 1'b0;
            chan_q      <= '0;
            cycles_q    <= '0;
        end else if (mon.clear) begin
            state       <= IDLE;
            persist_cnt <= '0;
            block_q     <= 1'b0;
            chan_q      <= '0;
            cycles_q    <= '0;
        end else if (enter_blk) begin
            // Cause and duration are captured only on entry, then held.
            state       <= BLOCKED;
            persist_cnt <= '0;
            block_q     <= 1'b1;
            chan_q      <= first_chan;
            cycles_q    <= CNT_W'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (cand) begin
                        state       <= SUSPECT;
                        persist_cnt <= PCNT_W'(1);
                    end
                end
                SUSPECT: begin
                    if (!cand) begin
                        state       <= IDLE;
                        persist_cnt <= '0;
                    end else begin
                        persist_cnt <= persist_cnt + PCNT_W'(1);
                    end
                end
                BLOCKED: begin
                    if (stay_blk) begin
                        cycles_q <= CNT_W'(sat_inc(64'(cycles_q), 64'(CNT_MAX)));
                    end else begin
                        state   <= IDLE;
                        block_q <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    persist_cnt <= '0;
                    block_q     <= 1'b0;
                end
            endcase
        end
    end

    assign mon.block          = block_q;
    assign mon.block_chan_idx = chan_q;
    assign mon.block_cycles   = cycles_q;

endmodule

// File: doc/pfb_deadlock_monitor_param.md
Name: pfb_deadlock_monitor_param

Overview:
- Parametrised next-generation deadlock monitor for HLS dataflow instances in the PFB/correlator chain.
- Watches N_AXIS stream-block flags and N_INST instance-block flags through a per-channel enable mask.
- Requires a persistence threshold before flagging; optional sticky latch.
- Reports the first blocking channel and a saturating blocked-duration count to the debug/status fabric.

Parameters:
- N_AXIS, 2, number of AXI-stream block inputs (>=1)
- N_INST, 1, number of instance block inputs (>=1)
- CHAN_MASK, all ones (N_AXIS bits), per-channel enable; 0 = channel ignored
- INST_EN, 0, 1 = inst_block_sigs also contribute to candidate
- THRESH, 1, consecutive candidate cycles before block asserts (>=1; 1 = legacy single-cycle behaviour)
- STICKY, 0, 1 = block holds until clear
- CNT_W, 16, width of block_cycles
- CHAN_W, clog2(N_AXIS+1), width of block_chan_idx (derived, not overridden)

Ports:
- clock  in  1  single clock domain, rising edge
- reset  in  1  asynchronous, active-low reset; deassertion is synchronised externally
- axis_block_sigs  in  N_AXIS  per-stream blocked flags
- inst_idle_sigs  in  N_INST  per-instance idle; status only, no effect on detection
- inst_block_sigs  in  N_INST  per-instance blocked flags
- clear  in  1  synchronous clear of state, latch and counters
- block  out  1  registered deadlock flag
- block_chan_idx  out  CHAN_W  lowest-index blocking channel captured at entry to BLOCKED; N_AXIS = instance-only cause
- block_cycles  out  CNT_W  cycles spent in BLOCKED, saturating at all ones

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, persist_cnt=0
  - block=0, block_chan_idx=0, block_cycles=0
- Candidate (combinational):
  - axis_cand = |(axis_block_sigs & CHAN_MASK)
  - cand = axis_cand | (INST_EN & |inst_block_sigs)
- States: IDLE, SUSPECT, BLOCKED.
  - IDLE: cand & THRESH==1 -> BLOCKED; cand & THRESH>1 -> SUSPECT with persist_cnt=1; else stay.
  - SUSPECT: !cand -> IDLE with persist_cnt=0. cand & persist_cnt==THRESH-1 -> BLOCKED. Otherwise persist_cnt+1.
  - BLOCKED: !cand & STICKY==0 -> IDLE. STICKY==1 -> stay until clear.
- persist_cnt width is clog2(THRESH+1); it never exceeds THRESH-1.
- block is registered and equals (state==BLOCKED).
- Latency: cand first high in cycle k (sampled at edge k) -> block=1 after edge k+THRESH-1. Legacy THRESH=1 gives a one-edge registered delay.
- Chan-idx capture (on the transition into BLOCKED only; held while BLOCKED):
  - block_chan_idx = lowest i with axis_block_sigs[i] & CHAN_MASK[i].
  - If no axis bit qualifies (instance-only cause), block_chan_idx = N_AXIS.
- block_cycles:
  - Loads 1 on entry to BLOCKED.
  - Increments each cycle in BLOCKED; saturates, no wrap.
  - Holds its last value after leaving BLOCKED; reloads on the next entry.
- clear:
  - Priority over every transition except reset: next state IDLE, persist_cnt=0, block_cycles=0, block_chan_idx=0.
  - Simultaneous clear & cand: clear wins; cand is evaluated again from the next cycle.
- Candidate dropping for exactly one cycle in SUSPECT restarts persistence from zero.
- Masked-off channels never create a candidate and are never reported.
- inst_idle_sigs is unused for detection; it is reserved for later modes and must not be optimised out of the port list.

Decomposition:
- Package pfb_deadlock_pkg:
  - state enum (IDLE=2'd0, SUSPECT=2'd1, BLOCKED=2'd2)
  - clog2 constant function
  - saturating-increment helper
- Sub-module pfb_deadlock_prio_enc: parametrised lowest-index priority encoder, N inputs -> clog2(N+1) index plus valid; returns N when no input is set.

Test Plan:
- Defaults (N_AXIS=2, THRESH=1): axis_block_sigs=2'b10 held 3 cycles, then 0 -> block=1 one edge after the first sample and 0 one edge after release; block_chan_idx=1; block_cycles=3.
- THRESH=4: candidate held 3 cycles, dropped 1 cycle, held 4 cycles -> block stays 0 through the first burst and rises after edge 4 of the second burst.
- STICKY=1: block reached, then axis_block_sigs=0 for 10 cycles -> block stays 1 and block_cycles reaches 11 (1 on entry plus 10 further cycles); clear pulse -> block=0 and block_cycles=0 next edge.
- CHAN_MASK=2'b01: axis_block_sigs=2'b10 for 20 cycles -> block stays 0. INST_EN=1 with inst_block_sigs=1 -> block=1 and block_chan_idx=2.
- CNT_W=4: BLOCKED held 20 cycles -> block_cycles saturates at 15 with no wrap.
- Reset mid-SUSPECT (THRESH=8, cnt=5): reset low asynchronously -> all outputs 0 immediately; after release, block needs 8 fresh candidate cycles. Same-cycle clear & cand -> state IDLE.
